// File: rtl/fadd_unit.sv
// Registered ripple-carry adder built from explicit full-adder cells; one-cycle latency.
// Optional FADD_PARITY_EN adds a registered sum_parity output (XOR of {cout, sum}).
module fadd_unit #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [CNT_W-1:0] txn_count
`ifdef FADD_PARITY_EN
    ,
    output logic             sum_parity
`endif
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] sum_d;
    logic             ovf_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic [CNT_W-1:0] txn_count_q;

    assign carry[0] = cin;

    // One full-adder cell per bit; carry ripples LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign prop[i]      = a[i] ^ b[i];
        assign gen[i]       = a[i] & b[i];
        assign sum_d[i]     = prop[i] ^ carry[i];
        assign carry[i + 1] = gen[i] | (carry[i] & prop[i]);
    end

    // Signed overflow: carry into the MSB differs from carry out of it.
    assign ovf_d = carry[WIDTH-1] ^ carry[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            txn_count_q <= '0;
        end else if (in_valid) begin
            out_valid_q <= 1'b1;
            sum_q       <= sum_d;
            cout_q      <= carry[WIDTH];
            ovf_q       <= ovf_d;
            txn_count_q <= txn_count_q + CNT_W'(1);
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign txn_count = txn_count_q;

`ifdef FADD_PARITY_EN
    logic sum_parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_parity_q <= 1'b0;
        end else if (in_valid) begin
            sum_parity_q <= ^{carry[WIDTH], sum_d};
        end
    end

    assign sum_parity = sum_parity_q;
`endif

endmodule

// File: tb/tb_fadd_unit.sv
// Self-checking bench for fadd_unit: WIDTH=1, WIDTH=4 and a CNT_W=2 instance against
// an arithmetic reference model.
module tb_fadd_unit;

    logic clk;
    logic rst;

    logic       iv1, a1, b1, cin1;
    logic       ov1, cout1, ovf1;
    logic [0:0] sum1;
    logic [7:0] cnt1;

    logic       iv4, cin4;
    logic [3:0] a4, b4;
    logic       ov4, cout4, ovf4;
    logic [3:0] sum4;
    logic [7:0] cnt4;

    logic       ivc, cinc;
    logic [3:0] ac, bc;
    logic       ovc, coutc, ovfc;
    logic [3:0] sumc;
    logic [1:0] cntc;

`ifdef FADD_PARITY_EN
    logic par1, par4, parc;
`endif

    int n_checks;
    int n_fail;

    fadd_unit #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1),
        .out_valid(ov1), .sum(sum1), .cout(cout1), .ovf(ovf1), .txn_count(cnt1)
`ifdef FADD_PARITY_EN
        , .sum_parity(par1)
`endif
    );

    fadd_unit #(.WIDTH(4), .CNT_W(8)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4), .cin(cin4),
        .out_valid(ov4), .sum(sum4), .cout(cout4), .ovf(ovf4), .txn_count(cnt4)
`ifdef FADD_PARITY_EN
        , .sum_parity(par4)
`endif
    );

    fadd_unit #(.WIDTH(4), .CNT_W(2)) uc (
        .clk(clk), .rst(rst), .in_valid(ivc), .a(ac), .b(bc), .cin(cinc),
        .out_valid(ovc), .sum(sumc), .cout(coutc), .ovf(ovfc), .txn_count(cntc)
`ifdef FADD_PARITY_EN
        , .sum_parity(parc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer sum, signed overflow from operand/result sign bits.
    function automatic void ref_add(input int unsigned w, input int unsigned x,
                                    input int unsigned y, input int unsigned ci,
                                    output logic [3:0] s, output logic co,
                                    output logic ov, output logic par);
        int unsigned total, sa, sb, ss;
        total = x + y + ci;
        s     = 4'(total % (1 << w));
        co    = ((total >> w) & 1) != 0;
        sa    = (x >> (w - 1)) & 1;
        sb    = (y >> (w - 1)) & 1;
        ss    = (total >> (w - 1)) & 1;
        ov    = (sa == sb) && (ss != sa);
        par   = ($countones(total) % 2) != 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_cnt4;

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({ov1, sum1, cout1, ovf1, cnt1} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_w1: got %b required 0", {ov1, sum1, cout1, ovf1, cnt1});
        end
        n_checks++;
        if ({ov4, sum4, cout4, ovf4, cnt4} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_w4: got %b required 0", {ov4, sum4, cout4, ovf4, cnt4});
        end
        n_checks++;
        if ({ovc, sumc, coutc, ovfc, cntc} !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_cnt2: got %b required 0", {ovc, sumc, coutc, ovfc, cntc});
        end
        rst = 1'b0;
        exp_cnt4 = 0;
    endtask

    task automatic test_w1_exhaustive();
        logic [3:0] s;
        logic co, ov, par;
        for (int i = 0; i < 8; i++) begin
            iv1 = 1'b1;
            a1 = i[2]; b1 = i[1]; cin1 = i[0];
            ref_add(1, int'(i[2]), int'(i[1]), int'(i[0]), s, co, ov, par);
            tick();
            n_checks++;
            if ({ov1, sum1, cout1, ovf1} !== {1'b1, s[0], co, ov}) begin
                n_fail++;
                $display("FAIL w1_combo%0d: got v/s/c/o=%b required %b", i,
                         {ov1, sum1, cout1, ovf1}, {1'b1, s[0], co, ov});
            end
            n_checks++;
            if (cnt1 !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL w1_count%0d: got %0d required %0d", i, cnt1, i + 1);
            end
        end
        iv1 = 1'b0;
        tick();
        n_checks++;
        if (ov1 !== 1'b0 || cnt1 !== 8'd8) begin
            n_fail++;
            $display("FAIL w1_after: got valid=%b count=%0d required 0/8", ov1, cnt1);
        end
    endtask

    task automatic test_w4_directed();
        iv4 = 1'b1; a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0;
        tick();
        exp_cnt4++;
        n_checks++;
        if ({ov4, sum4, cout4, ovf4} !== {1'b1, 4'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL w4_F_plus_1: got %b required 1_0000_1_0", {ov4, sum4, cout4, ovf4});
        end
        a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0;
        tick();
        exp_cnt4++;
        n_checks++;
        if ({ov4, sum4, cout4, ovf4} !== {1'b1, 4'h8, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL w4_7_plus_1: got %b required 1_1000_0_1", {ov4, sum4, cout4, ovf4});
        end
`ifdef FADD_PARITY_EN
        a4 = 4'hA; b4 = 4'h5; cin4 = 1'b1;
        tick();
        exp_cnt4++;
        n_checks++;
        if ({sum4, cout4, par4} !== {4'h0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL w4_parity: got sum/cout/par=%b required 0000_1_1",
                     {sum4, cout4, par4});
        end
`endif
        iv4 = 1'b0;
        tick();
        n_checks++;
        if (cnt4 !== 8'(exp_cnt4)) begin
            n_fail++;
            $display("FAIL w4_count: got %0d required %0d", cnt4, exp_cnt4);
        end
    endtask

    task automatic test_idle_hold();
        iv4 = 1'b1; a4 = 4'h3; b4 = 4'h4; cin4 = 1'b1;
        tick();
        exp_cnt4++;
        n_checks++;
        if ({ov4, sum4, cout4, ovf4} !== {1'b1, 4'h8, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL idle_accept: got %b required 1_1000_0_1", {ov4, sum4, cout4, ovf4});
        end
        iv4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                a4 = 'x; b4 = 'z; cin4 = 1'bx;
            end else begin
                a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            end
            tick();
            n_checks++;
            if ({ov4, sum4, cout4, ovf4, cnt4} !== {1'b0, 4'h8, 1'b0, 1'b1, 8'(exp_cnt4)}) begin
                n_fail++;
                $display("FAIL idle_hold%0d: got v/s/c/o/n=%b required %b", i,
                         {ov4, sum4, cout4, ovf4, cnt4},
                         {1'b0, 4'h8, 1'b0, 1'b1, 8'(exp_cnt4)});
            end
        end
    endtask

    task automatic test_reset_midstream();
        rst = 1'b1; iv4 = 1'b1; a4 = 4'h5; b4 = 4'($urandom); cin4 = 1'b0;
        tick();
        n_checks++;
        if ({ov4, sum4, cout4, ovf4, cnt4} !== 15'h0) begin
            n_fail++;
            $display("FAIL midreset_zero: got %b required 0", {ov4, sum4, cout4, ovf4, cnt4});
        end
        rst = 1'b0; iv4 = 1'b0;
        tick();
        n_checks++;
        if (ov4 !== 1'b0 || cnt4 !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_discard: got valid=%b count=%0d required 0/0", ov4, cnt4);
        end
        iv4 = 1'b1; a4 = 4'h1; b4 = 4'h2; cin4 = 1'b0;
        tick();
        iv4 = 1'b0;
        exp_cnt4 = 1;
        n_checks++;
        if ({ov4, sum4, cnt4} !== {1'b1, 4'h3, 8'd1}) begin
            n_fail++;
            $display("FAIL midreset_next: got v/s/n=%b required 1_0011_00000001",
                     {ov4, sum4, cnt4});
        end
    endtask

    task automatic test_counter_wrap();
        logic [3:0] s;
        logic co, ov, par;
        int unsigned x, y, ci;
        int exp_seq[5] = '{1, 2, 3, 0, 1};
        for (int i = 0; i < 5; i++) begin
            x = $urandom_range(15); y = $urandom_range(15); ci = $urandom_range(1);
            ivc = 1'b1; ac = 4'(x); bc = 4'(y); cinc = 1'(ci);
            ref_add(4, x, y, ci, s, co, ov, par);
            tick();
            n_checks++;
            if ({ovc, sumc, coutc, ovfc, cntc} !== {1'b1, s, co, ov, 2'(exp_seq[i])}) begin
                n_fail++;
                $display("FAIL wrap%0d: got v/s/c/o/n=%b required %b", i,
                         {ovc, sumc, coutc, ovfc, cntc}, {1'b1, s, co, ov, 2'(exp_seq[i])});
            end
        end
        ivc = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] s, e_sum4;
        logic co, ov, par, e_cout4, e_ovf4, e_par4, e_v4;
        logic e_sum1, e_cout1, e_ovf1, e_par1, e_v1;
        int unsigned x, y, ci;
        int e_cnt1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e_sum4 = '0; e_cout4 = 0; e_ovf4 = 0; e_par4 = 0; e_v4 = 0; exp_cnt4 = 0;
        e_sum1 = 0; e_cout1 = 0; e_ovf1 = 0; e_par1 = 0; e_v1 = 0; e_cnt1 = 0;
        for (int i = 0; i < 300; i++) begin
            iv4 = ($urandom_range(3) != 0);
            x = $urandom_range(15); y = $urandom_range(15); ci = $urandom_range(1);
            a4 = 4'(x); b4 = 4'(y); cin4 = 1'(ci);
            e_v4 = iv4;
            if (iv4) begin
                ref_add(4, x, y, ci, s, co, ov, par);
                e_sum4 = s; e_cout4 = co; e_ovf4 = ov; e_par4 = par;
                exp_cnt4 = (exp_cnt4 + 1) % 256;
            end
            iv1 = ($urandom_range(1) != 0);
            x = $urandom_range(1); y = $urandom_range(1); ci = $urandom_range(1);
            a1 = 1'(x); b1 = 1'(y); cin1 = 1'(ci);
            e_v1 = iv1;
            if (iv1) begin
                ref_add(1, x, y, ci, s, co, ov, par);
                e_sum1 = s[0]; e_cout1 = co; e_ovf1 = ov; e_par1 = par;
                e_cnt1 = (e_cnt1 + 1) % 256;
            end
            tick();
            n_checks++;
            if ({ov4, sum4, cout4, ovf4, cnt4} !==
                {e_v4, e_sum4, e_cout4, e_ovf4, 8'(exp_cnt4)}) begin
                n_fail++;
                $display("FAIL rand_w4_%0d: got v/s/c/o/n=%b required %b", i,
                         {ov4, sum4, cout4, ovf4, cnt4},
                         {e_v4, e_sum4, e_cout4, e_ovf4, 8'(exp_cnt4)});
            end
            n_checks++;
            if ({ov1, sum1, cout1, ovf1, cnt1} !==
                {e_v1, e_sum1, e_cout1, e_ovf1, 8'(e_cnt1)}) begin
                n_fail++;
                $display("FAIL rand_w1_%0d: got v/s/c/o/n=%b required %b", i,
                         {ov1, sum1, cout1, ovf1, cnt1},
                         {e_v1, e_sum1, e_cout1, e_ovf1, 8'(e_cnt1)});
            end
`ifdef FADD_PARITY_EN
            n_checks++;
            if ({par4, par1} !== {e_par4, e_par1}) begin
                n_fail++;
                $display("FAIL rand_parity_%0d: got %b required %b", i, {par4, par1},
                         {e_par4, e_par1});
            end
`endif
        end
        iv4 = 1'b0; iv1 = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        iv4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        ivc = 1'b0; ac = 4'h0; bc = 4'h0; cinc = 1'b0;
        @(negedge clk);
        test_reset();
        test_w1_exhaustive();
        test_w4_directed();
        test_idle_hold();
        test_reset_midstream();
        test_counter_wrap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
